// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } inflight_t;

  localparam int MEM_WORD_BYTES = 4;
  localparam int WORD_LSB       = $clog2(MEM_WORD_BYTES);

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes plus single-port RAM bus shared by the arbiter and its environment.
interface mem_port_arbiter_if #(
  parameter int AW = 10
);
  import mem_arb_pkg::*;

  logic                   i_req;
  logic [AW-1:0]          i_addr;
  logic                   i_ack;
  logic [31:0]            i_rdata;

  logic                   d_req;
  logic                   d_we;
  logic [AW-1:0]          d_addr;
  logic [3:0]             d_wmask;
  logic [31:0]            d_wdata;
  logic                   d_ack;
  logic [31:0]            d_rdata;

  logic                   ram_en;
  logic                   ram_we;
  logic [3:0]             ram_wmask;
  logic [AW-WORD_LSB-1:0] ram_addr;
  logic [31:0]            ram_wdata;
  logic [31:0]            ram_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wmask, d_wdata, ram_rdata,
    output i_ack, i_rdata, d_ack, d_rdata,
    output ram_en, ram_we, ram_wmask, ram_addr, ram_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wmask, d_wdata, ram_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata,
    input  ram_en, ram_we, ram_wmask, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_arb_stall_counter.sv
// Free-running 32-bit event counter with enable; wraps naturally at 2^32.
module mem_arb_stall_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and load/store ports onto one registered-read RAM port.
// Define MEM_ARB_STATS_EN to add per-port stall counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
`ifdef MEM_ARB_STATS_EN
  output logic [31:0] i_stall_cnt,
  output logic [31:0] d_stall_cnt,
`endif
  mem_port_arbiter_if.slave bus
);

  localparam int AW = $clog2(MEMORY_DEPTH);

  inflight_t r_inflight;
  inflight_t w_grant;
  logic      w_i_elig;
  logic      w_d_elig;
  logic      w_unused_addr_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= IDLE;
    end else begin
      r_inflight <= w_grant;
    end
  end

  // A port whose ack is due this cycle still shows its old req, so it is masked.
  always_comb begin
    w_i_elig      = bus.i_req && (r_inflight != INST);
    w_d_elig      = bus.d_req && (r_inflight != DATA);
    w_grant       = IDLE;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_wmask = 4'b0000;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (!rst) begin
      if (w_d_elig) begin
        w_grant = DATA;
      end else if (w_i_elig) begin
        w_grant = INST;
      end
    end
    case (w_grant)
      DATA: begin
        bus.ram_en    = 1'b1;
        bus.ram_we    = bus.d_we;
        bus.ram_wmask = bus.d_wmask;
        bus.ram_addr  = bus.d_addr[AW-1:WORD_LSB];
        bus.ram_wdata = bus.d_wdata;
      end
      INST: begin
        bus.ram_en   = 1'b1;
        bus.ram_addr = bus.i_addr[AW-1:WORD_LSB];
      end
      default: ;
    endcase
    // Gating with rst drops the ack of an access interrupted by reset.
    bus.i_ack   = (r_inflight == INST) && !rst;
    bus.d_ack   = (r_inflight == DATA) && !rst;
    bus.i_rdata = bus.ram_rdata;
    bus.d_rdata = bus.ram_rdata;
  end

  assign w_unused_addr_bits = ^{bus.i_addr[WORD_LSB-1:0], bus.d_addr[WORD_LSB-1:0]};

`ifdef MEM_ARB_STATS_EN
  logic w_i_stall;
  logic w_d_stall;

  assign w_i_stall = w_i_elig && (w_grant != INST);
  assign w_d_stall = w_d_elig && (w_grant != DATA);

  mem_arb_stall_counter u_i_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_i_stall),
    .o_count (i_stall_cnt)
  );

  mem_arb_stall_counter u_d_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_d_stall),
    .o_count (d_stall_cnt)
  );
`endif

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous RAM between the core's instruction-fetch port and its load/store port. Each requester uses a req/ack handshake, and the arbiter returns read data one cycle after grant. The block sits between `rv32i_core` and a single-port main memory. It replaces the dual-read combinational memory so that the design maps onto a single block-RAM port.

## Interface
Parameters:
- `MEMORY_DEPTH`, 1024: memory size in bytes; must be a power of two, ≥ 8.
- `AW`, `$clog2(MEMORY_DEPTH)`: byte-address width (derived; not overridden).

Ports:
- `clk` in 1: the single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_req` in 1: instruction read request; held high until `i_ack`.
- `i_addr` in AW: instruction byte address; bits [1:0] ignored.
- `i_ack` out 1: one-cycle pulse; `i_rdata` valid in this cycle.
- `i_rdata` out 32: instruction word.
- `d_req` in 1: data request; held high with stable inputs until `d_ack`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in AW: data byte address; bits [1:0] ignored.
- `d_wmask` in 4: byte-lane write mask.
- `d_wdata` in 32: write data.
- `d_ack` out 1: one-cycle pulse; `d_rdata` valid in this cycle (for reads).
- `d_rdata` out 32: read data word.
- `ram_en` out 1: RAM access strobe.
- `ram_we` out 1: RAM write enable.
- `ram_wmask` out 4: RAM byte mask.
- `ram_addr` out AW-2: RAM word address.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: registered RAM output, valid one cycle after `ram_en`.

## Operation
- In-flight state `inflight` ∈ {IDLE, INST, DATA} records which port was granted in the previous cycle.
- Eligibility:
  - `i_req` is eligible when `inflight != INST`.
  - `d_req` is eligible when `inflight != DATA`.
  - This masks a port whose ack is due this cycle, because its `req` is still the old request.
- Grant: data wins if eligible; otherwise instruction; otherwise no grant.
- Grant cycle drives RAM combinationally:
  - `ram_en`=1.
  - `ram_addr` = granted addr[AW-1:2].
  - For the data port: `ram_we`=`d_we`, `ram_wmask`=`d_wmask`, `ram_wdata`=`d_wdata`.
  - For the instruction port: `ram_we`=0, `ram_wmask`=0.
- No grant: `ram_en`=0, `ram_we`=0, `ram_wmask`=0. `ram_addr` and `ram_wdata` are don't-care (drive 0).
- `inflight` next = granted port, or IDLE if none.
- Ack and data:
  - `i_ack` = (`inflight`==INST); `d_ack` = (`inflight`==DATA). Both are combinational from the register.
  - `i_rdata` = `d_rdata` = `ram_rdata`.
  - Writes also ack; `d_rdata` is don't-care for writes.
- Under continuous contention, grants alternate D, I, D, I…, so neither port can starve.
- A write commits at the edge ending its grant cycle. A read granted in the next cycle to the same word returns the new data.
- Requester protocol violations (dropping `req` or changing inputs before ack) are undefined. The arbiter does not guard against them.

## Timing
- Read latency: grant in cycle N, ack with data in cycle N+1.
- Per-port throughput: one access every 2 cycles; aggregate throughput is one access per cycle.
- The next request from the same port is grantable at N+2.
- Reset values: `inflight`=IDLE. In the first cycle after reset, `i_ack`=`d_ack`=0.
- The RAM outputs are combinational from `req`, so they follow requests in the same cycle even during reset release.
- Reset during an in-flight access: its ack is never emitted. A write granted before the reset edge has already committed.
- Reset asserted in a cycle: `ram_en` is forced to 0 (no grant).

## Configuration
- `MEM_ARB_STATS_EN` defined: adds two outputs.
  - `i_stall_cnt`, 32 bits: increments when `i_req`=1 and not granted and `inflight`!=INST.
  - `d_stall_cnt`, 32 bits: same rule for the data port.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

## Structure
- Shared package `mem_arb_pkg`:
  - `inflight_t` enum: IDLE=2'd0, INST=2'd1, DATA=2'd2.
  - Constant `MEM_WORD_BYTES`=4.
- One natural sub-module, `mem_arb_stall_counter`: a 32-bit saturate-free counter with enable. It is instantiated twice, only under `MEM_ARB_STATS_EN`.

## Test plan
- Isolated instruction read:
  - Memory word 5 = 0xDEADBEEF.
  - `i_req`, `i_addr`=0x14 at cycle 0 → `ram_en`=1, `ram_addr`=5 at cycle 0.
  - `i_ack`=1 with `i_rdata`=0xDEADBEEF at cycle 1; no ack at cycle 2.
- Simultaneous requests:
  - Both `req`s held continuously.
  - Grants D, I, D, I on cycles 0–3; acks `d_ack` at 1, `i_ack` at 2, `d_ack` at 3.
- Byte write, then read-back:
  - Word 2 preset to 0x11223344.
  - `d_we`=1, `d_addr`=0x08, `d_wmask`=4'b0010, `d_wdata`=0x0000AA00.
  - Then an instruction read of 0x08 → `i_rdata`=0x1122AA44.
- Reset mid-access: `rst` in the cycle after a data-read grant → no `d_ack`; `inflight`=IDLE; the next request is served normally.
- Idle: no `req`s for 10 cycles → `ram_en`=0 and both acks 0 throughout.
- Stats build (with `MEM_ARB_STATS_EN`): both ports requesting for 4 cycles → `i_stall_cnt`=1, `d_stall_cnt`=0.
